// File: rtl/ft232h_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// ft232h_tx_scheduler_if
// Avalon-MM register-access bundle between the TX scheduler (master) and the
// FT232H Avalon bridge (slave).
//   master_address     : bridge register address
//   master_write       : write request, held until waitrequest is low
//   master_writedata   : write data, payload byte in [7:0]
//   master_read        : single-cycle read request
//   master_readdata    : read data, valid the cycle after master_read
//   master_waitrequest : bridge stall for writes
// ---------------------------------------------------------------------------
interface ft232h_tx_scheduler_if;
  logic [7:0]  master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_waitrequest;

  modport master (
    output master_address, master_write, master_writedata, master_read,
    input  master_readdata, master_waitrequest
  );

  modport slave (
    input  master_address, master_write, master_writedata, master_read,
    output master_readdata, master_waitrequest
  );
endinterface

// File: rtl/ft232h_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ft232h_tx_scheduler
// Shares the FT232H transmit path between NUM_CH byte-stream requesters.
// Programs the bridge TX threshold/control registers after reset, polls the
// TX FIFO counter, grants one requester round-robin and writes a framed
// burst (header 0xA<g> followed by BURST_LEN payload bytes) to WRITE_DATA.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   ch_req           : per-channel "BURST_LEN bytes buffered" level
//   ch_data          : per-channel FWFT byte, channel i at [8i+7:8i]
//   ch_pop           : one-hot accept strobe for the granted channel
//   grant            : one-hot current grant (0 when none)
//   burst_done       : 1-cycle pulse after the final payload byte
//   busy             : high in every state except IDLE
//   tx_almost_empty  : bridge TX irq level
//   bus              : Avalon-MM master port (ft232h_tx_scheduler_if.master)
//
// Build option: TX_IRQ_WAIT_EN -- wait for tx_almost_empty (and clear the
// irq) instead of timed backoff polling when FIFO space is short.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// CFG_THR  | write TX threshold register
// CFG_CTRL | write control register (irq enable or 0)
// IDLE     | wait for any request
// POLL_RD  | 1-cycle read of TX FIFO counter
// POLL_CHK | compare free space against one framed burst
// BACKOFF  | timed wait before re-polling
// ARB      | round-robin pick starting after last grant
// HDR      | write header byte
// DATA     | write payload bytes, pop granted channel
// IRQ_WAIT | wait for tx_almost_empty
// IRQ_CLR  | clear the tx irq
// ---------------------------------------------------------------------------
module ft232h_tx_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int BURST_LEN     = 64,
  parameter int FIFO_DEPTH    = 1024,
  parameter int TX_THRESHOLD  = 256,
  parameter int POLL_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [8*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]     ch_pop,
  output logic [NUM_CH-1:0]     grant,
  output logic                  burst_done,
  output logic                  busy,
  input  logic                  tx_almost_empty,
  ft232h_tx_scheduler_if.master bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL + 1) : 1;

  localparam logic [7:0] ADDR_WR   = 8'd1;
  localparam logic [7:0] ADDR_CNT  = 8'd3;
  localparam logic [7:0] ADDR_THR  = 8'd5;
  localparam logic [7:0] ADDR_CLR  = 8'd6;
  localparam logic [7:0] ADDR_CTRL = 8'd7;

`ifdef TX_IRQ_WAIT_EN
  localparam logic [31:0] CTRL_VAL = 32'h2;
`else
  localparam logic [31:0] CTRL_VAL = 32'h0;
`endif

  localparam logic [10:0] DEPTH   = 11'(FIFO_DEPTH);
  localparam logic [10:0] NEED    = 11'(BURST_LEN + 1);
  localparam logic [7:0]  LAST    = 8'(BURST_LEN - 1);
  localparam logic [TW-1:0] BO_LD = TW'(POLL_INTERVAL - 1);

  typedef enum logic [3:0] {
    CFG_THR, CFG_CTRL, IDLE, POLL_RD, POLL_CHK, BACKOFF,
    ARB, HDR, DATA, IRQ_WAIT, IRQ_CLR
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d, rd_q, rd_d, done_q, done_d, busy_q;
  logic [7:0]        addr_q, addr_d, cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CW-1:0]     gsel_q, gsel_d, ptr_q, ptr_d, arb_g;
  logic [TW-1:0]     bo_q, bo_d;
  logic              arb_hit, wr_done;
  logic [10:0]       fill, free;
  int                idx;

  assign wr_done = wr_q & ~bus.master_waitrequest;

  // Bridge never reports more than its depth; clamp anyway so free never wraps.
  assign fill = {1'b0, bus.master_readdata[9:0]};
  assign free = (fill > DEPTH) ? 11'd0 : DEPTH - fill;

  always_comb begin
    arb_hit = 1'b0;
    arb_g   = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (!arb_hit && ch_req[idx]) begin
        arb_hit = 1'b1;
        arb_g   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    gsel_d  = gsel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    case (state_q)
      CFG_THR: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = ADDR_THR;
          wdata_d = {22'h0, 10'(TX_THRESHOLD)};
        end else if (wr_done) begin
          state_d = CFG_CTRL;
          addr_d  = ADDR_CTRL;
          wdata_d = CTRL_VAL;
        end
      end
      CFG_CTRL: if (wr_done) begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
      IDLE: if (|ch_req) begin
        state_d = POLL_RD;
        rd_d    = 1'b1;
        addr_d  = ADDR_CNT;
      end
      POLL_RD: state_d = POLL_CHK;
      POLL_CHK: begin
        if (free >= NEED) begin
          state_d = ARB;
        end else begin
`ifdef TX_IRQ_WAIT_EN
          state_d = IRQ_WAIT;
`else
          state_d = BACKOFF;
          bo_d    = BO_LD;
`endif
        end
      end
      BACKOFF: begin
        if (bo_q == '0) begin
          state_d = POLL_RD;
          rd_d    = 1'b1;
          addr_d  = ADDR_CNT;
        end else begin
          bo_d = bo_q - 1'b1;
        end
      end
      ARB: begin
        if (arb_hit) begin
          state_d = HDR;
          grant_d = NUM_CH'(1) << arb_g;
          gsel_d  = arb_g;
          ptr_d   = arb_g;
          wr_d    = 1'b1;
          addr_d  = ADDR_WR;
          wdata_d = {24'h0, 4'hA, 4'(arb_g)};
        end else begin
          state_d = IDLE;
        end
      end
      HDR: if (wr_done) begin
        state_d = DATA;
        cnt_d   = 8'd0;
      end
      DATA: if (wr_done) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
      IRQ_WAIT: if (tx_almost_empty) begin
        state_d = IRQ_CLR;
        wr_d    = 1'b1;
        addr_d  = ADDR_CLR;
        wdata_d = 32'h2;
      end
      IRQ_CLR: if (wr_done) begin
        state_d = POLL_RD;
        wr_d    = 1'b0;
        rd_d    = 1'b1;
        addr_d  = ADDR_CNT;
      end
      default: state_d = CFG_THR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CFG_THR;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= '0;
      gsel_q  <= '0;
      ptr_q   <= CW'(NUM_CH - 1);
      cnt_q   <= '0;
      bo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      gsel_q  <= gsel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Payload is taken live from the FWFT head: after a pop the channel has
  // already advanced, so a registered copy would be one byte stale.
  assign bus.master_writedata = (state_q == DATA) ? {24'h0, ch_data[{gsel_q, 3'b000} +: 8]}
                                                  : wdata_q;
  assign bus.master_address   = addr_q;
  assign bus.master_write     = wr_q;
  assign bus.master_read      = rd_q;
  assign ch_pop     = (state_q == DATA && wr_done) ? grant_q : '0;
  assign grant      = grant_q;
  assign burst_done = done_q;
  assign busy       = busy_q;

  logic unused_ok;
`ifdef TX_IRQ_WAIT_EN
  assign unused_ok = &{1'b0, bus.master_readdata[31:10]};
`else
  assign unused_ok = &{1'b0, bus.master_readdata[31:10], tx_almost_empty};
`endif

endmodule

// File: tb/tb_ft232h_tx_scheduler.sv
module tb_ft232h_tx_scheduler;
  localparam int NCH = 4;
  localparam int BL  = 4;
  localparam int PI  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  ch_req;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]  ch_pop, grant;
  logic            burst_done, busy;
  logic            tx_almost_empty = 1'b0;
  logic            wreq = 1'b0;
  logic [31:0]     rdata = 32'h0;

  ft232h_tx_scheduler_if bus();
  assign bus.master_waitrequest = wreq;
  assign bus.master_readdata    = rdata;

  ft232h_tx_scheduler #(.NUM_CH(NCH), .BURST_LEN(BL), .FIFO_DEPTH(1024),
                        .TX_THRESHOLD(256), .POLL_INTERVAL(PI)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_data(ch_data),
    .ch_pop(ch_pop), .grant(grant), .burst_done(burst_done), .busy(busy),
    .tx_almost_empty(tx_almost_empty), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [3:0]  pop;
  } wr_t;

  typedef struct {
    logic [3:0] req;
    int         cnt;
    int         g;
  } vec_t;

  wr_t wq[$];
  int  rd_q[$];
  int  rd_cyc[$];
  int  total = 0, bad = 0;
  int  cyc = 0, n_done = 0, n_stall = 0, beat = 0, hdr_cyc = 0, stall_left = 0;
  int  ch_idx[NCH];
  int  exp_idx[NCH];
  wr_t mon_e;
  vec_t vecs[9];

  function automatic logic [7:0] byte_of(input int ch, input int idx);
    return 8'((ch * 64) + (idx % 64));
  endfunction

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NCH; i++) ch_data[8*i +: 8] = byte_of(i, ch_idx[i]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_cfg();
    wq.push_back('{8'h05, 32'h100, 4'h0, 4'h0});
    wq.push_back('{8'h07, 32'h0, 4'h0, 4'h0});
  endtask

  task automatic push_burst(input int g);
    logic [3:0] oh;
    oh = 4'(1 << g);
    wq.push_back('{8'h01, {24'h0, 4'hA, 4'(g)}, oh, 4'h0});
    for (int k = 0; k < BL; k++) begin
      wq.push_back('{8'h01, {24'h0, byte_of(g, exp_idx[g])}, oh, oh});
      exp_idx[g]++;
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    int start;
    start = n_done;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      if (n_done > start) break;
    end
    #1;
    chk({name, "_done_seen"}, 32'(n_done > start), 32'h1);
    chk({name, "_writes_left"}, 32'(wq.size()), 32'h0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_grant"}, 32'(grant), 32'h0);
    chk({name, "_pop"}, 32'(ch_pop), 32'h0);
    chk({name, "_done"}, 32'(burst_done), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_write"}, 32'(bus.master_write), 32'h0);
    chk({name, "_read"}, 32'(bus.master_read), 32'h0);
    chk({name, "_addr"}, 32'(bus.master_address), 32'h0);
    chk({name, "_wdata"}, bus.master_writedata, 32'h0);
  endtask

  always @(posedge clk) cyc++;

  // Write stall model: hold waitrequest while the 2nd payload byte is pending.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0 && beat == 1 && bus.master_write) begin
      wreq = 1'b1;
      stall_left--;
    end else begin
      wreq = 1'b0;
    end
  end

  // Bus monitor / bridge model / scoreboard consumer / channel FIFOs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.master_read) begin
        rd_cyc.push_back(cyc);
        if (rd_q.size() > 0) rdata = 32'(rd_q.pop_front());
        else rdata = 32'h0;
      end
      if (bus.master_write) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                   bus.master_address, bus.master_writedata);
        end else if (wreq) begin
          chk("stall_addr", 32'(bus.master_address), 32'(wq[0].addr));
          chk("stall_data", bus.master_writedata, wq[0].data);
          chk("stall_pop", 32'(ch_pop), 32'h0);
          n_stall++;
        end else begin
          mon_e = wq.pop_front();
          chk("wr_addr", 32'(bus.master_address), 32'(mon_e.addr));
          chk("wr_data", bus.master_writedata, mon_e.data);
          chk("wr_grant", 32'(grant), 32'(mon_e.grant));
          chk("wr_pop", 32'(ch_pop), 32'(mon_e.pop));
          if (mon_e.pop != 4'h0) begin
            beat++;
            for (int i = 0; i < NCH; i++) if (ch_pop[i]) ch_idx[i]++;
          end else if (mon_e.addr == 8'h01) begin
            beat = 0;
            hdr_cyc = cyc;
          end
        end
      end else if (ch_pop != '0) begin
        chk("pop_without_write", 32'(ch_pop), 32'h0);
      end
      if (burst_done) n_done++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int i = 0; i < NCH; i++) begin
      ch_idx[i]  = 0;
      exp_idx[i] = 0;
    end
    vecs[0] = '{4'b1111, 0,    0};
    vecs[1] = '{4'b1111, 0,    1};
    vecs[2] = '{4'b1111, 0,    2};
    vecs[3] = '{4'b1111, 0,    3};
    vecs[4] = '{4'b1111, 0,    0};
    vecs[5] = '{4'b0100, 0,    2};
    vecs[6] = '{4'b1001, 1019, 3};
    vecs[7] = '{4'b1001, 0,    0};
    vecs[8] = '{4'b0010, 0,    1};

    rst_n  = 1'b0;
    ch_req = '0;
    #12;
    chk_outputs_zero("reset");
    push_cfg();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("cfg_writes_left", 32'(wq.size()), 32'h0);
    chk("cfg_busy", 32'(busy), 32'h0);
    chk("cfg_no_reads", 32'(rd_cyc.size()), 32'h0);

    // Round-robin and single-request vectors, including the exact-fit space case.
    for (int i = 0; i < 9; i++) begin
      rd_q.push_back(vecs[i].cnt);
      push_burst(vecs[i].g);
      ch_req = vecs[i].req;
      wait_done(60, "vec");
    end
    ch_req = '0;
    repeat (8) @(posedge clk);
    #1;

    // Insufficient space: backoff then reread.
    n0 = rd_cyc.size();
    rd_q.push_back(1020);
    rd_q.push_back(0);
    push_burst(0);
    ch_req = 4'b0001;
    wait_done(80, "backoff");
    ch_req = '0;
    if (rd_cyc.size() >= n0 + 2) begin
      chk("reread_gap", 32'(rd_cyc[n0+1] - rd_cyc[n0]), 32'(PI + 2));
      chk("hdr_after_reread", 32'(hdr_cyc > rd_cyc[n0+1]), 32'h1);
    end else begin
      chk("reread_count", 32'(rd_cyc.size() - n0), 32'h2);
    end
    repeat (8) @(posedge clk);
    #1;

    // Waitrequest on the 2nd payload byte.
    n_stall    = 0;
    stall_left = 3;
    push_burst(2);
    ch_req = 4'b0100;
    wait_done(60, "stall");
    ch_req = '0;
    chk("stall_cycles", 32'(n_stall), 32'h3);
    repeat (8) @(posedge clk);
    #1;

    // Reset while the 3rd payload byte is pending.
    push_burst(3);
    ch_req = 4'b1000;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (beat == 2) break;
    end
    chk("pre_reset_beat", 32'(beat), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    wq.delete();
    exp_idx[3] = exp_idx[3] - (BL - 2);
    ch_req = '0;
    push_cfg();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("recfg_writes_left", 32'(wq.size()), 32'h0);
    chk("recfg_busy", 32'(busy), 32'h0);

    // Pointer is back at reset value; channel 3 resumes at its 3rd byte.
    push_burst(3);
    ch_req = 4'b1000;
    wait_done(60, "post_rst");
    ch_req = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("burst_total", 32'(n_done), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ft232h_tx_scheduler.md
Name: ft232h_tx_scheduler

Overview:
Avalon-MM master that shares the FT232H transmit path between NUM_CH byte-stream requesters.
- After reset it programs the USB bridge's TX threshold and control registers.
- It checks TX FIFO free space, grants one requester round-robin, and writes one framed burst (1 header byte plus BURST_LEN payload bytes) into the bridge's WRITE_DATA register.
- It sits between on-chip producers (ADC/log channels) and the FT232H Avalon bridge, on the same clk domain as the bridge's Avalon side.

Parameters:
NUM_CH, 4, number of requesters (2..16)
BURST_LEN, 64, payload bytes per grant (1..255)
FIFO_DEPTH, 1024, bridge TX FIFO depth in bytes
TX_THRESHOLD, 256, value written to bridge TX almost-empty threshold (10 bits)
POLL_INTERVAL, 16, idle cycles between counter polls when space is insufficient (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ch_req  input  NUM_CH  per-channel level: at least BURST_LEN bytes are buffered
ch_data  input  8*NUM_CH  per-channel first-word-fall-through byte; channel i is bits [8i+7:8i]
ch_pop  output  NUM_CH  one-hot strobe: granted channel's current byte was accepted
grant  output  NUM_CH  one-hot current grant, 0 when none
burst_done  output  1  1-cycle pulse after the final payload byte of a burst completes
busy  output  1  high in every state except IDLE
master_address  output  8  bridge register address
master_write  output  1  write request
master_writedata  output  32  write data; payload occupies bits [7:0]
master_read  output  1  read request
master_readdata  input  32  bridge read data, valid 1 cycle after master_read
master_waitrequest  input  1  bridge stall
tx_almost_empty  input  1  bridge TX irq level

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - State is CFG_THR.
  - Round-robin pointer is NUM_CH-1, so channel 0 has first priority.
  - Byte counter is 0.
- Bridge addresses are fixed: WRITE_DATA=1, TX_FIFO_COUNTER=3, TX_THRESHOLD=5, CLEAR_IRQ=6, CONTROL=7.
- Write handshake:
  - Address, data and master_write are held stable until a cycle in which master_waitrequest=0.
  - The write completes in that cycle.
  - master_write deasserts the next cycle unless another write follows back-to-back.
- Read handshake:
  - master_read is asserted for exactly 1 cycle; waitrequest is ignored for reads.
  - master_readdata[9:0] is sampled on the following cycle.
- State machine:
  - CFG_THR: write TX_THRESHOLD to address 5. -> CFG_CTRL.
  - CFG_CTRL: write 32'h2 (tx irq enable) to address 7 if TX_IRQ_WAIT_EN is defined, else 32'h0. -> IDLE.
  - IDLE: busy=0. If any ch_req -> POLL_RD.
  - POLL_RD: 1-cycle read of address 3. -> POLL_CHK.
  - POLL_CHK: free = FIFO_DEPTH - readdata[9:0], computed at 11 bits, no wrap.
    - free >= BURST_LEN+1 -> ARB.
    - Otherwise -> BACKOFF (or IRQ_WAIT with the macro).
  - BACKOFF: count POLL_INTERVAL cycles. -> POLL_RD.
  - ARB: scan ch_req starting at pointer+1, wrapping modulo NUM_CH.
    - On a hit: grant = one-hot(g), pointer = g. -> HDR.
    - No request set -> IDLE, grant stays 0.
  - HDR: write {24'h0, 4'hA, g[3:0]} to address 1. On completion -> DATA with counter = 0.
  - DATA: write {24'h0, ch_data[g]} to address 1.
    - ch_pop[g]=1 in exactly the cycle the write completes.
    - Counter increments on each completion.
    - After completion with counter == BURST_LEN-1: grant=0, burst_done pulses next cycle. -> IDLE.
- ch_req is sampled only in IDLE and ARB. Dropping ch_req mid-burst does not abort the burst; the requester guarantees BURST_LEN bytes.
- Latency: with no waitrequest, a burst takes 1+BURST_LEN consecutive write cycles, back-to-back with no bubble between HDR and DATA or between DATA bytes.
- Waitrequest during DATA: the held byte is ch_data at entry. The channel must keep ch_data stable while ch_pop is 0.
- Reset mid-operation: aborts immediately without any completion or pop. After release, CFG_THR reruns.

Optional Feature:
TX_IRQ_WAIT_EN
- Defined:
  - CFG_CTRL enables the tx irq.
  - Insufficient space in POLL_CHK -> IRQ_WAIT, which waits for tx_almost_empty=1.
  - Then IRQ_CLR writes 32'h2 to address 6. -> POLL_RD.
  - BACKOFF is unused.
- Undefined: fixed POLL_INTERVAL backoff polling; tx_almost_empty is ignored.

Test Plan:
- Reset release, waitrequest=0 -> writes (5, 256) then (7, 0), busy=0, no reads.
- ch_req=4'b0100, counter reads 0, BURST_LEN=4 -> writes to address 1: 0xA2 then 4 data bytes; ch_pop[2] 4 pulses; grant=4'b0100 throughout; burst_done once.
- ch_req=4'b1111 held, counter 0 -> grant order 0,1,2,3,0.
- Counter read returns 1020 (free 4 < BURST_LEN+1 = 5) -> no writes, reread exactly POLL_INTERVAL+2 cycles later; then 0 -> burst proceeds.
- master_waitrequest held 3 cycles on the 2nd data byte -> address/data held, ch_pop only on release; byte order intact.
- rst_n low during the 3rd data byte -> outputs 0 asynchronously; after release the config writes repeat. With TX_IRQ_WAIT_EN and counter 1023: waits for tx_almost_empty, then writes (6, 2).
